// File: rtl/note_tone_gen.sv
// Square-wave tone generator: an octave prescaler and a note counter time each half-period.
// New notes wait in a one-deep slot and take effect only at a half-period boundary.
module note_tone_gen #(
  parameter int DIV_W = 9,
  parameter int OCT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] note_div,
  input  logic [OCT_W-1:0] octave,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic             mute,
  output logic             speaker,
  output logic             playing
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state, state_d;
  logic             pend_full;
  logic [DIV_W-1:0] pend_div, cur_div, cur_div_d, note_cnt, note_cnt_d;
  logic [OCT_W-1:0] pend_oct, cur_oct, cur_oct_d;
  logic [7:0]       oct_cnt, oct_cnt_d;
  logic             phase, phase_d, consume;

  // Prescaler reload halves per octave; the top two octaves share the floor of 3.
  function automatic logic [7:0] oct_reload(input logic [OCT_W-1:0] o);
    logic [7:0] r;
    r = 8'hFF >> o;
    if (r < 8'd3) r = 8'd3;
    return r;
  endfunction

  assign note_ready = ~pend_full;

  always_comb begin
    state_d    = state;
    phase_d    = phase;
    note_cnt_d = note_cnt;
    oct_cnt_d  = oct_cnt;
    cur_div_d  = cur_div;
    cur_oct_d  = cur_oct;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        phase_d = 1'b0;
        if (pend_full) begin
          consume = 1'b1;
          if (pend_div != '0) begin
            state_d    = PLAY;
            cur_div_d  = pend_div;
            cur_oct_d  = pend_oct;
            note_cnt_d = pend_div;
            oct_cnt_d  = oct_reload(pend_oct);
            phase_d    = 1'b1;
          end
        end
      end
      PLAY: begin
        if (oct_cnt != 8'd0) begin
          oct_cnt_d = oct_cnt - 1'b1;
        end else begin
          oct_cnt_d = oct_reload(cur_oct);
          if (note_cnt != '0) begin
            note_cnt_d = note_cnt - 1'b1;
          end else begin
            // Half-period boundary: the only point where a pending note may take over.
            phase_d = ~phase;
            if (pend_full) begin
              consume = 1'b1;
              if (pend_div != '0) begin
                cur_div_d  = pend_div;
                cur_oct_d  = pend_oct;
                note_cnt_d = pend_div;
                oct_cnt_d  = oct_reload(pend_oct);
              end else begin
                state_d = IDLE;
                phase_d = 1'b0;
              end
            end else begin
              note_cnt_d = cur_div;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= 1'b0;
      note_cnt <= '0;
      oct_cnt  <= 8'd0;
      cur_div  <= '0;
      cur_oct  <= '0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      note_cnt <= note_cnt_d;
      oct_cnt  <= oct_cnt_d;
      cur_div  <= cur_div_d;
      cur_oct  <= cur_oct_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_div  <= '0;
      pend_oct  <= '0;
    end else if (consume) begin
      pend_full <= 1'b0;
    end else if (note_valid && !pend_full) begin
      pend_full <= 1'b1;
      pend_div  <= note_div;
      pend_oct  <= octave;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speaker <= 1'b0;
      playing <= 1'b0;
    end else begin
      speaker <= phase & ~mute;
      playing <= (state == PLAY);
    end
  end

endmodule
